// File: rtl/core_pkg.sv
// Shared decode definitions for the operand-fetch stage: opcode class
// constants, the instruction class enum and the operand-select encoding.
package core_pkg;

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_S,
    CLS_B,
    CLS_U,
    CLS_OTHER
  } op_class_e;

  typedef enum logic {
    ASEL_ZERO,
    ASEL_RS1
  } a_sel_e;

  typedef enum logic {
    BSEL_RS2,
    BSEL_IMM
  } b_sel_e;

  typedef struct packed {
    a_sel_e a_sel;
    b_sel_e b_sel;
    logic   use_rs1;
    logic   use_rs2;    // rs2 is read and also forwarded as ex_rs2_val
    logic   writes_rd;
  } op_ctrl_t;

  function automatic op_class_e classify(input logic [6:0] opcode);
    case (opcode[6:2])
      OPC_OP:                        return CLS_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return CLS_I;
      OPC_STORE:                     return CLS_S;
      OPC_BRANCH:                    return CLS_B;
      OPC_LUI:                       return CLS_U;
      default:                       return CLS_OTHER;
    endcase
  endfunction

  function automatic op_ctrl_t decode_ctrl(input op_class_e cls);
    op_ctrl_t c;
    c = '{a_sel: ASEL_ZERO, b_sel: BSEL_IMM, use_rs1: 1'b0, use_rs2: 1'b0, writes_rd: 1'b1};
    case (cls)
      CLS_R: c = '{a_sel: ASEL_RS1, b_sel: BSEL_RS2, use_rs1: 1'b1, use_rs2: 1'b1, writes_rd: 1'b1};
      CLS_I: c = '{a_sel: ASEL_RS1, b_sel: BSEL_IMM, use_rs1: 1'b1, use_rs2: 1'b0, writes_rd: 1'b1};
      CLS_S: c = '{a_sel: ASEL_RS1, b_sel: BSEL_IMM, use_rs1: 1'b1, use_rs2: 1'b1, writes_rd: 1'b0};
      CLS_B: c = '{a_sel: ASEL_RS1, b_sel: BSEL_RS2, use_rs1: 1'b1, use_rs2: 1'b1, writes_rd: 1'b0};
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// NREG x XLEN register file: two combinational read ports, one synchronous
// write port, asynchronous clear. Entry 0 always reads zero and ignores writes.
module regfile_2r1w #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      ra1_i,
  output logic [XLEN-1:0] rd1_o,
  input  logic [4:0]      ra2_i,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] mem_q [NREG];

  // Storage: cleared on reset, written on enabled non-zero address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources from the register file, tracks
// outstanding destinations in a pending scoreboard, stalls on RAW/WAW
// hazards and registers the selected operands toward execute.
// Optional same-cycle writeback bypass: define OPERAND_FETCH_BYPASS_EN.
module operand_fetch #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [6:0]      dec_opcode,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  input  logic [XLEN-1:0] dec_imm,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [6:0]      ex_opcode,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [XLEN-1:0] ex_rs2_val
);

  import core_pkg::*;

  op_class_e       cls;
  op_ctrl_t        ctrl;
  logic [XLEN-1:0] rf_rs1, rf_rs2, rs1_val, rs2_val;
  logic [NREG-1:1] pending_q, pending_d;
  logic            wb_write, wb_hit_rs1, wb_hit_rs2;
  logic            pend_rs1, pend_rs2, pend_rd;
  logic            haz_rs1, haz_rs2, hazard, accept;
  logic [XLEN-1:0] op_a_d, op_b_d, rs2_val_d;

  logic            ex_valid_q;
  logic [6:0]      ex_opcode_q;
  logic [4:0]      ex_rd_q;
  logic [XLEN-1:0] ex_op_a_q, ex_op_b_q, ex_rs2_val_q;

  assign cls  = classify(dec_opcode);
  assign ctrl = decode_ctrl(cls);

  regfile_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk_i  (clk),
    .rst_ni (rst),
    .ra1_i  (dec_rs1),
    .rd1_o  (rf_rs1),
    .ra2_i  (dec_rs2),
    .rd2_o  (rf_rs2),
    .we_i   (wb_en),
    .wa_i   (wb_rd),
    .wd_i   (wb_data)
  );

  assign wb_write   = wb_en && (wb_rd != '0);
  assign wb_hit_rs1 = wb_write && (wb_rd == dec_rs1);
  assign wb_hit_rs2 = wb_write && (wb_rd == dec_rs2);
  assign pend_rs1   = (dec_rs1 != '0) && pending_q[dec_rs1];
  assign pend_rs2   = (dec_rs2 != '0) && pending_q[dec_rs2];
  assign pend_rd    = ctrl.writes_rd && (dec_rd != '0) && pending_q[dec_rd];

`ifdef OPERAND_FETCH_BYPASS_EN
  assign rs1_val = wb_hit_rs1 ? wb_data : rf_rs1;
  assign rs2_val = wb_hit_rs2 ? wb_data : rf_rs2;
  assign haz_rs1 = ctrl.use_rs1 && pend_rs1 && !wb_hit_rs1;
  assign haz_rs2 = ctrl.use_rs2 && pend_rs2 && !wb_hit_rs2;
`else
  assign rs1_val = rf_rs1;
  assign rs2_val = rf_rs2;
  assign haz_rs1 = ctrl.use_rs1 && (pend_rs1 || wb_hit_rs1);
  assign haz_rs2 = ctrl.use_rs2 && (pend_rs2 || wb_hit_rs2);
`endif

  assign hazard    = haz_rs1 || haz_rs2 || pend_rd;
  assign dec_ready = rst && (!ex_valid_q || ex_ready) && !hazard;
  assign accept    = dec_valid && dec_ready;

  assign op_a_d    = (ctrl.a_sel == ASEL_RS1) ? rs1_val : '0;
  assign op_b_d    = (ctrl.b_sel == BSEL_RS2) ? rs2_val : dec_imm;
  assign rs2_val_d = ctrl.use_rs2 ? rs2_val : '0;

  // Scoreboard update: writeback clears first so a same-cycle issue set wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_write) pending_d[wb_rd] = 1'b0;
    if (accept && ctrl.writes_rd && (dec_rd != '0)) pending_d[dec_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  // Execute-side output register: load on accept, drop valid once consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q   <= 1'b0;
      ex_opcode_q  <= '0;
      ex_rd_q      <= '0;
      ex_op_a_q    <= '0;
      ex_op_b_q    <= '0;
      ex_rs2_val_q <= '0;
    end else if (accept) begin
      ex_valid_q   <= 1'b1;
      ex_opcode_q  <= dec_opcode;
      ex_rd_q      <= dec_rd;
      ex_op_a_q    <= op_a_d;
      ex_op_b_q    <= op_b_d;
      ex_rs2_val_q <= rs2_val_d;
    end else if (ex_ready) begin
      ex_valid_q   <= 1'b0;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_opcode  = ex_opcode_q;
  assign ex_rd      = ex_rd_q;
  assign ex_op_a    = ex_op_a_q;
  assign ex_op_b    = ex_op_b_q;
  assign ex_rs2_val = ex_rs2_val_q;

endmodule
